sync_fifo_thresh: RTL

- Parametrised single-clock FIFO buffer; successor to the basic cs/rd/we FIFO controller.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags with clear.
- Defined simultaneous read/write behaviour at the full and empty boundaries.
- Sits between a producer and a consumer in the same clock domain.

---
 rtl/sync_fifo_thresh.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sync_fifo_thresh.sv
// sync_fifo_thresh: single-clock FIFO with an occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Optional macro SYNC_FIFO_FWFT_EN selects first-word fall-through output
// (0-cycle read latency). When it is undefined, dataOut is a register with a
// 1-cycle read latency.
module sync_fifo_thresh #(
  parameter int WIDTH    = 8,
  parameter int ADDR     = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             we,
  input  logic             rd,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dataOut,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [ADDR:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int            CELLS    = 1 << ADDR;
  localparam logic [ADDR:0] LP_CELLS = (ADDR+1)'(CELLS);
  localparam logic [ADDR:0] LP_AF    = (ADDR+1)'(AF_LEVEL);
  localparam logic [ADDR:0] LP_AE    = (ADDR+1)'(AE_LEVEL);

  logic [WIDTH-1:0] r_mem [CELLS];
  logic [ADDR-1:0]  r_wr_ptr;
  logic [ADDR-1:0]  r_rd_ptr;
  logic [ADDR:0]    r_count;
  logic             r_empty;
  logic             r_full;
  logic             r_almost_empty;
  logic             r_almost_full;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_rd_ok;
  logic             w_wr_ok;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic             w_clr;
  logic [ADDR:0]    w_count_next;

  // A read needs data present; a write may land on a full FIFO only when the
  // same edge frees a slot.
  assign w_rd_ok   = cs & rd & ~r_empty;
  assign w_wr_ok   = cs & we & (~r_full | w_rd_ok);
  assign w_ovf_set = cs & we & r_full & ~w_rd_ok;
  assign w_unf_set = cs & rd & r_empty;
  assign w_clr     = cs & clr_err;

  // Occupancy after this edge; simultaneous push and pop cancel out.
  always_comb begin
    w_count_next = r_count;
    if (w_wr_ok && !w_rd_ok) begin
      w_count_next = r_count + 1'b1;
    end else if (w_rd_ok && !w_wr_ok) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= dataIn;
    end
  end

  // Pointers, count, and status flags decoded from the next count so they
  // line up with count in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_empty <= 1'b1;
      r_almost_full  <= 1'b0;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count        <= w_count_next;
      r_empty        <= (w_count_next == '0);
      r_full         <= (w_count_next == LP_CELLS);
      r_almost_empty <= (w_count_next <= LP_AE);
      r_almost_full  <= (w_count_next >= LP_AF);
      // A fresh error in the clearing cycle keeps its flag set.
      r_overflow     <= w_clr ? w_ovf_set : (r_overflow  | w_ovf_set);
      r_underflow    <= w_clr ? w_unf_set : (r_underflow | w_unf_set);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is visible as soon as it is stored; a pop advances to the next.
  assign dataOut = r_empty ? '0 : r_mem[r_rd_ptr];
`else
  logic [WIDTH-1:0] r_dout;

  // Registered read port: updates only on an accepted read, holds otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dout <= '0;
    end else if (w_rd_ok) begin
      r_dout <= r_mem[r_rd_ptr];
    end
  end

  assign dataOut = r_dout;
`endif

  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_empty = r_almost_empty;
  assign almost_full  = r_almost_full;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
